// File: rtl/dw_add_accum.sv
// Frame accumulator for the adder's {CO, SUM} stream: sums every beat of a frame
// into a wide register and presents total, sticky overflow and beat count.
module dw_add_accum #(
    parameter int width     = 32,
    parameter int acc_width = 40,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [width-1:0]     in_data,
    input  logic                 in_co,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [acc_width-1:0] out_sum,
    output logic                 out_ovf,
    output logic [cnt_width-1:0] out_count,
    output logic [1:0]           dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
    // valid never depends on ready, and the producer holds its payload until it transfers.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                state, state_next;
    logic                  accept, start;
    logic [acc_width-1:0]  operand, acc, acc_sum, acc_next;
    logic                  carry, ovf, ovf_next;
    logic [cnt_width-1:0]  cnt, cnt_next;

    assign out_valid = (state == HOLD);
    assign in_ready  = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign dbg_state = state;

    // Any beat outside an open frame, or one flagged first, restarts the frame.
    assign start = (state != ACCUM) | in_first;

    always_comb begin
        operand            = '0;
        operand[width:0]   = {in_co, in_data};
        {carry, acc_sum}   = {1'b0, acc} + {1'b0, operand};
        acc_next           = start ? operand : acc_sum;
        ovf_next           = start ? 1'b0 : (ovf | carry);
        if (start)
            cnt_next = cnt_width'(1);
        else if (&cnt)
            cnt_next = cnt;
        else
            cnt_next = cnt + cnt_width'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (accept)
            state_next = in_last ? HOLD : ACCUM;
        else if (state == HOLD && out_ready)
            state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            ovf <= ovf_next;
            if (in_last) begin
                out_sum   <= acc_next;
                out_ovf   <= ovf_next;
                out_count <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_dw_add_accum.sv
// Bench for dw_add_accum (width=8, acc_width=12, cnt_width=4): directed frames
// plus randomized traffic checked against a frame-level arithmetic model.
module tb_dw_add_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_co;
    logic        in_first;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic        out_ovf;
    logic [3:0]  out_count;
    logic [1:0]  dbg_state;

    dw_add_accum #(.width(8), .acc_width(12), .cnt_width(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_co(in_co),
        .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // expected results {ovf, count[3:0], sum[11:0]} awaiting consumption
    logic [16:0] exp_q[$];
    int          frame_q[$];
    bit          frame_open = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // model: a frame's result is the plain integer sum of its beats
    task automatic model_accept(input logic [8:0] beat, input logic f, input logic l);
        int total;
        int n;
        if (!frame_open || f) frame_q.delete();
        frame_q.push_back(int'(beat));
        frame_open = 1;
        if (l) begin
            total = 0;
            foreach (frame_q[i]) total += frame_q[i];
            n = frame_q.size();
            exp_q.push_back({total > 4095, 4'((n > 15) ? 15 : n), 12'(total % 4096)});
            frame_open = 0;
        end
    endtask

    // driver: present inputs for one cycle, check at negedge, advance to posedge+1
    task automatic cycle(input logic v, input logic [8:0] beat, input logic f,
                         input logic l, input logic r);
        logic exp_rdy;
        logic [16:0] e;
        in_valid  = v;
        {in_co, in_data} = beat;
        in_first  = f;
        in_last   = l;
        out_ready = r;
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("out_sum", 32'(out_sum), 32'(e[11:0]));
            check("out_count", 32'(out_count), 32'(e[15:12]));
            check("out_ovf", 32'(out_ovf), 32'(e[16]));
        end
        exp_rdy = (exp_q.size() == 0) || r;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
        if (v && exp_rdy) model_accept(beat, f, l);
        @(posedge clk);
        #1;
    endtask

    // directed result check against hand-computed values, right after the last beat
    task automatic peek(input string tag, input logic [11:0] s, input logic o, input logic [3:0] c);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".sum"}, 32'(out_sum), 32'(s));
        check({tag, ".ovf"}, 32'(out_ovf), 32'(o));
        check({tag, ".count"}, 32'(out_count), 32'(c));
    endtask

    task automatic do_reset();
        in_valid = 0;
        out_ready = 0;
        reset = 1;
        #2;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_sum", 32'(out_sum), 32'd0);
        check("rst.out_ovf", 32'(out_ovf), 32'd0);
        check("rst.out_count", 32'(out_count), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        frame_q.delete();
        frame_open = 0;
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        reset = 1; in_valid = 0; in_data = 0; in_co = 0;
        in_first = 0; in_last = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 1: three-beat frame
        cycle(1, 9'h0FF, 1, 0, 1);
        cycle(1, 9'h1FF, 0, 0, 1);
        cycle(1, 9'h001, 0, 1, 1);
        peek("t1", 12'h2FF, 0, 4'd3);

        // 2: ten beats of 0x1FF overflow the 12-bit accumulator
        for (int i = 0; i < 10; i++) cycle(1, 9'h1FF, i == 0, i == 9, 1);
        peek("t2", 12'h3F6, 1, 4'd10);

        // 3: beat counter saturates
        for (int i = 0; i < 20; i++) cycle(1, 9'h001, i == 0, i == 19, 1);
        peek("t3", 12'h014, 0, 4'hF);

        // 4: single-beat frame
        cycle(1, 9'h0A5, 1, 1, 1);
        peek("t4", 12'h0A5, 0, 4'd1);

        // 5: backpressure, then retire and start in the same cycle
        for (int i = 0; i < 5; i++) cycle(1, 9'($urandom_range(0, 511)), 1, 1, 0);
        peek("t5.held", 12'h0A5, 0, 4'd1);
        cycle(1, 9'h003, 1, 1, 1);
        peek("t5", 12'h003, 0, 4'd1);

        // 6: reset in mid-frame
        cycle(1, 9'h050, 1, 0, 1);
        cycle(1, 9'h060, 0, 0, 1);
        do_reset();
        cycle(1, 9'h004, 1, 1, 1);
        peek("t6", 12'h004, 0, 4'd1);

        // 7: in_first inside an open frame discards the partial sum
        cycle(1, 9'h010, 1, 0, 1);
        cycle(1, 9'h020, 0, 0, 1);
        cycle(1, 9'h005, 1, 0, 1);
        cycle(1, 9'h001, 0, 1, 1);
        peek("t7", 12'h006, 0, 4'd2);
        cycle(0, 9'h000, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle($urandom_range(0, 9) < 7,
                  ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 511)),
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) < 6);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
